// File: rtl/proof_stim_pkg.sv
// Shared types and constants for the equivalence-proof stimulus source.
package proof_stim_pkg;

    // Sweep controller states (encoding is visible on the debug port).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } stim_state_e;

    // Operand source selection, latched on an accepted start.
    localparam logic MODE_SWEEP = 1'b0;
    localparam logic MODE_LFSR  = 1'b1;

    // Maximal-length Fibonacci tap masks for an n-bit LFSR (n = 4..16).
    // Bit k set means register bit k feeds the XOR; the register shifts
    // left with the feedback entering bit 0.
    function automatic logic [15:0] lfsr_taps(input int n);
        logic [15:0] t;
        case (n)
            4:       t = 16'h000C;
            5:       t = 16'h0014;
            6:       t = 16'h0030;
            7:       t = 16'h0060;
            8:       t = 16'h00B8;
            9:       t = 16'h0110;
            10:      t = 16'h0240;
            11:      t = 16'h0500;
            12:      t = 16'h0829;
            13:      t = 16'h100D;
            14:      t = 16'h2015;
            15:      t = 16'h6000;
            16:      t = 16'hD008;
            default: t = 16'h000C;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/proof_delay_line.sv
// Delays an operand pair and its valid tag by LAT enabled cycles.
// With LAT = 0 the pair passes straight through combinationally.
module proof_delay_line #(
    parameter int W   = 4,
    parameter int LAT = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           en_i,
    input  logic [2*W-1:0] data_i,
    input  logic           valid_i,
    output logic [2*W-1:0] data_o,
    output logic           valid_o
);

    if (LAT == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = clk_i ^ rst_ni ^ en_i;
        assign data_o      = data_i;
        assign valid_o     = valid_i;
    end else begin : g_pipe
        logic [2*W-1:0] data_q [LAT];
        logic [LAT-1:0] valid_q;

        // Shift the pair and its valid tag one stage per enabled cycle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < LAT; i++) data_q[i] <= '0;
                valid_q <= '0;
            end else if (en_i) begin
                data_q[0]  <= data_i;
                valid_q[0] <= valid_i;
                for (int i = 1; i < LAT; i++) begin
                    data_q[i]  <= data_q[i-1];
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        assign data_o  = data_q[LAT-1];
        assign valid_o = valid_q[LAT-1];
    end

endmodule

// File: rtl/proof_stim_gen.sv
// Operand source for equivalence proofs: issues pairs to the evaluator and
// the same pairs, LAT cycles later, to the golden branch with check_en.
// Handshake: there is no backpressure except stall; a pair is issued on
// every cycle in FILL/RUN with stall low, and check_en marks the cycle the
// delayed copy of that pair is on num1/num2 (never while stall is high).
module proof_stim_gen
    import proof_stim_pkg::*;
#(
    parameter int          W    = 4,
    parameter int          LAT  = 1,
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic         stall,
    output logic [W-1:0] a_num1,
    output logic [W-1:0] a_num2,
    output logic [W-1:0] num1,
    output logic [W-1:0] num2,
    output logic         check_en,
    output logic         busy,
    output logic         done,
    output logic [2*W:0] check_cnt,
    output logic [2:0]   dbg_state
);

    localparam int            PW       = 2 * W;
    localparam int            CW       = PW + 1;
    localparam logic [15:0]   TAPS_ALL = lfsr_taps(PW);
    localparam logic [PW-1:0] TAPS     = TAPS_ALL[PW-1:0];
    localparam logic [PW-1:0] SEED_LO  = SEED[PW-1:0];
    localparam logic [PW-1:0] SEED_EFF = (SEED_LO == '0) ? PW'(1) : SEED_LO;
    localparam logic [2:0]    LAT_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    stim_state_e   state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic          mode_q, mode_d;
    logic [PW-1:0] pair_q, pair_d;
    logic [PW-1:0] lfsr_q, lfsr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          start_ok;
    logic          issue;
    logic          last_pair;
    logic [PW-1:0] lfsr_nxt;
    logic [PW-1:0] dl_data;
    logic          dl_valid;
    logic          dl_en;

    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign issue     = (state_q == ST_FILL || state_q == ST_RUN) && !stall;
    assign lfsr_nxt  = {lfsr_q[PW-2:0], ^(lfsr_q & TAPS)};
    // Sweep ends on the all-ones pair, or when the LFSR would revisit its seed.
    assign last_pair = (mode_q == MODE_SWEEP) ? (pair_q == '1) : (lfsr_nxt == SEED_EFF);
    assign busy      = (state_q == ST_FILL) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign dl_en     = busy && !stall;
    assign check_en  = dl_valid && !stall && (state_q == ST_RUN || state_q == ST_DRAIN);

    proof_delay_line #(
        .W   (W),
        .LAT (LAT)
    ) u_delay (
        .clk_i   (clk),
        .rst_ni  (rst),
        .en_i    (dl_en),
        .data_i  (pair_q),
        .valid_i (issue),
        .data_o  (dl_data),
        .valid_o (dl_valid)
    );

    // Next-state logic: FILL and DRAIN each last LAT non-stalled cycles.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (LAT > 0) ? ST_FILL : ST_RUN;
                    phase_d = 3'd0;
                end
            end
            ST_FILL: begin
                if (!stall) begin
                    if (phase_q == LAT_LAST) begin
                        state_d = ST_RUN;
                        phase_d = 3'd0;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
            end
            ST_RUN: begin
                if (issue && last_pair) begin
                    state_d = (LAT > 0) ? ST_DRAIN : ST_DONE;
                    phase_d = 3'd0;
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    if (phase_q == LAT_LAST) state_d = ST_DONE;
                    else                     phase_d = phase_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand generator and check counter updates.
    always_comb begin
        pair_d = pair_q;
        lfsr_d = lfsr_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (start_ok) begin
            mode_d = mode;
            cnt_d  = '0;
            pair_d = (mode == MODE_LFSR) ? lfsr_q : '0;
        end else begin
            if (issue) begin
                if (mode_q == MODE_LFSR) lfsr_d = lfsr_nxt;
                if (!last_pair) pair_d = (mode_q == MODE_LFSR) ? lfsr_nxt : pair_q + PW'(1);
            end
            if (check_en && cnt_q != '1) cnt_d = cnt_q + CW'(1);
        end
    end

    // State and datapath registers; stall holds everything via the _d defaults.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            phase_q <= 3'd0;
            mode_q  <= MODE_SWEEP;
            pair_q  <= '0;
            lfsr_q  <= SEED_EFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            pair_q  <= pair_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a_num1    = pair_q[PW-1:W];
    assign a_num2    = pair_q[W-1:0];
    assign num1      = dl_data[PW-1:W];
    assign num2      = dl_data[W-1:0];
    assign check_cnt = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_proof_stim_gen.sv
// Bench for proof_stim_gen: three instances (LAT = 0, 1, 3) with W = 4.
module tb_proof_stim_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       start [3];
    logic       stall [3];
    logic [3:0] a1 [3];
    logic [3:0] a2 [3];
    logic [3:0] n1 [3];
    logic [3:0] n2 [3];
    logic       ce [3];
    logic       bsy [3];
    logic       dn [3];
    logic [8:0] cnt [3];
    logic [2:0] st [3];

    int n_pass  = 0;
    int n_total = 0;

    // clock
    always #5 clk = ~clk;

    proof_stim_gen #(.W(4), .LAT(0), .SEED(16'h0001)) u_lat0 (
        .clk(clk), .rst(rst), .start(start[0]), .mode(mode), .stall(stall[0]),
        .a_num1(a1[0]), .a_num2(a2[0]), .num1(n1[0]), .num2(n2[0]),
        .check_en(ce[0]), .busy(bsy[0]), .done(dn[0]), .check_cnt(cnt[0]),
        .dbg_state(st[0])
    );

    proof_stim_gen #(.W(4), .LAT(1), .SEED(16'h0001)) u_lat1 (
        .clk(clk), .rst(rst), .start(start[1]), .mode(mode), .stall(stall[1]),
        .a_num1(a1[1]), .a_num2(a2[1]), .num1(n1[1]), .num2(n2[1]),
        .check_en(ce[1]), .busy(bsy[1]), .done(dn[1]), .check_cnt(cnt[1]),
        .dbg_state(st[1])
    );

    proof_stim_gen #(.W(4), .LAT(3), .SEED(16'h0001)) u_lat3 (
        .clk(clk), .rst(rst), .start(start[2]), .mode(mode), .stall(stall[2]),
        .a_num1(a1[2]), .a_num2(a2[2]), .num1(n1[2]), .num2(n2[2]),
        .check_en(ce[2]), .busy(bsy[2]), .done(dn[2]), .check_cnt(cnt[2]),
        .dbg_state(st[2])
    );

    typedef struct packed {
        logic       start;
        logic       stall;
        logic [3:0] a1;
        logic [3:0] a2;
        logic [3:0] n1;
        logic [3:0] n2;
        logic       ce;
        logic       busy;
        logic       done;
        logic [8:0] cnt;
    } vec_t;

    task automatic check_val(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Full sweep on instance idx, with optional stall window and a start
    // pulse while busy (carrying the opposite mode, which must be ignored).
    task automatic run_sweep(input int idx, input logic m, input int stall_lo,
                             input int stall_hi, input int busy_start_at,
                             input logic exp_done0, input int exp_total);
        logic       seen [256];
        logic [7:0] exp_pair;
        logic [7:0] prev_a;
        logic [7:0] prev_n;
        logic [8:0] prev_cnt;
        logic [7:0] cur_a;
        logic [7:0] cur_n;
        logic       prev_stall;
        logic       finished;
        int         checks;
        int         last_check_cyc;
        int         run_cycles;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        exp_pair       = 8'd0;
        prev_a         = 8'd0;
        prev_n         = 8'd0;
        prev_cnt       = 9'd0;
        prev_stall     = 1'b0;
        finished       = 1'b0;
        checks         = 0;
        last_check_cyc = -10;
        run_cycles     = 0;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk);
            start[idx] = (cyc == 0) || (cyc == busy_start_at);
            mode       = (cyc == busy_start_at) ? ~m : m;
            stall[idx] = (cyc >= stall_lo) && (cyc <= stall_hi);
            #1;
            cur_a = {a1[idx], a2[idx]};
            cur_n = {n1[idx], n2[idx]};
            if (cyc == 0) begin
                check_val($sformatf("sw%0d_c0_done", idx), int'(dn[idx]), int'(exp_done0));
                check_val($sformatf("sw%0d_c0_busy", idx), int'(bsy[idx]), 0);
            end else begin
                if (cyc == 1) begin
                    check_val($sformatf("sw%0d_c1_busy", idx), int'(bsy[idx]), 1);
                    check_val($sformatf("sw%0d_c1_done", idx), int'(dn[idx]), 0);
                    check_val($sformatf("sw%0d_c1_cnt", idx), int'(cnt[idx]), 0);
                    check_val($sformatf("sw%0d_c1_first", idx), int'(cur_a), m ? 1 : 0);
                end
                if (prev_stall) begin
                    check_val($sformatf("sw%0d_frz_a_c%0d", idx, cyc), int'(cur_a), int'(prev_a));
                    check_val($sformatf("sw%0d_frz_n_c%0d", idx, cyc), int'(cur_n), int'(prev_n));
                    check_val($sformatf("sw%0d_frz_cnt_c%0d", idx, cyc), int'(cnt[idx]), int'(prev_cnt));
                end
                if (stall[idx])
                    check_val($sformatf("sw%0d_stall_ce_c%0d", idx, cyc), int'(ce[idx]), 0);
                if (idx == 0) begin
                    check_val($sformatf("sw0_pass_c%0d", cyc), int'(cur_n), int'(cur_a));
                    check_val($sformatf("sw0_nofill_c%0d", cyc),
                              int'(st[0] == 3'd1 || st[0] == 3'd3), 0);
                    if (st[0] == 3'd2 && !stall[0]) begin
                        run_cycles++;
                        check_val($sformatf("sw0_run_ce_c%0d", cyc), int'(ce[0]), 1);
                    end
                end
                if (ce[idx]) begin
                    if (!m) begin
                        check_val($sformatf("sw%0d_order_c%0d", idx, cyc), int'(cur_n), int'(exp_pair));
                        exp_pair = exp_pair + 8'd1;
                    end else begin
                        check_val($sformatf("sw%0d_fresh_c%0d", idx, cyc),
                                  int'(!seen[cur_n] && cur_n != 8'd0), 1);
                        seen[cur_n] = 1'b1;
                    end
                    checks++;
                    last_check_cyc = cyc;
                end
                if (dn[idx]) begin
                    finished = 1'b1;
                    check_val($sformatf("sw%0d_done_lag", idx), cyc - last_check_cyc, 1);
                    check_val($sformatf("sw%0d_final_cnt", idx), int'(cnt[idx]), exp_total);
                    check_val($sformatf("sw%0d_final_checks", idx), checks, exp_total);
                    check_val($sformatf("sw%0d_final_busy", idx), int'(bsy[idx]), 0);
                    check_val($sformatf("sw%0d_final_ce", idx), int'(ce[idx]), 0);
                    if (!m) begin
                        check_val($sformatf("sw%0d_final_n", idx), int'(cur_n), 255);
                        check_val($sformatf("sw%0d_final_a", idx), int'(cur_a), 255);
                    end
                    if (idx == 0) check_val("sw0_run_cycles", run_cycles, 256);
                end
            end
            prev_a     = cur_a;
            prev_n     = cur_n;
            prev_cnt   = cnt[idx];
            prev_stall = stall[idx];
        end
        start[idx] = 1'b0;
        stall[idx] = 1'b0;
        mode       = 1'b0;
        if (!finished) check_val($sformatf("sw%0d_timeout", idx), 0, 1);
    endtask

    initial begin
        vec_t tv [9];
        logic found;

        // LAT = 1, mode 0: start, first issues, a two-cycle stall, start while busy.
        //           start stall a1 a2 n1 n2 ce busy done cnt
        tv[0] = {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 9'd0};
        tv[1] = {1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 9'd0};
        tv[2] = {1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 9'd0};
        tv[3] = {1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 9'd1};
        tv[4] = {1'b0, 1'b1, 4'd0, 4'd3, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0, 9'd2};
        tv[5] = {1'b0, 1'b1, 4'd0, 4'd3, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0, 9'd2};
        tv[6] = {1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 9'd2};
        tv[7] = {1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 9'd3};
        tv[8] = {1'b0, 1'b0, 4'd0, 4'd5, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 9'd4};

        // reset
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            stall[i] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rst%0d_outs", i),
                      int'({a1[i], a2[i], n1[i], n2[i]}), 0);
            check_val($sformatf("rst%0d_flags", i),
                      int'({ce[i], bsy[i], dn[i], cnt[i], st[i]}), 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // table-driven opening of a LAT = 1 sweep
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start[1] = tv[i].start;
            stall[1] = tv[i].stall;
            #1;
            check_val($sformatf("vec%0d_a", i), int'({a1[1], a2[1]}), int'({tv[i].a1, tv[i].a2}));
            check_val($sformatf("vec%0d_n", i), int'({n1[1], n2[1]}), int'({tv[i].n1, tv[i].n2}));
            check_val($sformatf("vec%0d_flags", i), int'({ce[1], bsy[1], dn[1]}),
                      int'({tv[i].ce, tv[i].busy, tv[i].done}));
            check_val($sformatf("vec%0d_cnt", i), int'(cnt[1]), int'(tv[i].cnt));
        end
        start[1] = 1'b0;
        stall[1] = 1'b0;

        // run on to pair 100, then pull reset between clock edges
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            #1;
            if ({n1[1], n2[1]} == 8'd100 && ce[1]) found = 1'b1;
        end
        check_val("pair100_reached", int'(found), 1);
        check_val("pair100_cnt", int'(cnt[1]), 100);
        rst = 1'b0;
        #1;
        check_val("midrst_outs", int'({a1[1], a2[1], n1[1], n2[1]}), 0);
        check_val("midrst_flags", int'({ce[1], bsy[1], dn[1], cnt[1]}), 0);
        check_val("midrst_state", int'(st[1]), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_val("postrst_ce", int'(ce[1]), 0);
        check_val("postrst_state", int'(st[1]), 0);

        // full sweeps
        run_sweep(1, 1'b0, -1, -1, 50, 1'b0, 256);
        run_sweep(1, 1'b1, -1, -1, -1, 1'b1, 255);
        run_sweep(2, 1'b0, 5, 8, -1, 1'b0, 256);
        run_sweep(0, 1'b0, -1, -1, -1, 1'b0, 256);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
